// File: rtl/conv_seq_addr_gen.sv
// Convolution MAC sequencer: emits one src/wgt/dst address beat per MAC on a valid/ready stream.
// First beat is valid one cycle after run rises. All outputs hold while out_valid & ~out_ready.
module conv_seq_addr_gen #(
   parameter int AW = 14
) (
   input  logic          S_AXI_ACLK,
   input  logic          S_AXI_ARESET,
   input  logic          run,
   input  logic [3:0]    id,
   input  logic [9:0]    is,
   input  logic [4:0]    iw,
   input  logic [9:0]    ks,
   input  logic [4:0]    kh,
   input  logic [4:0]    kw,
   input  logic [9:0]    fs,
   input  logic [3:0]    od,
   input  logic [9:0]    os,
   input  logic [4:0]    oh,
   input  logic [4:0]    ow,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] src_addr,
   output logic [AW-1:0] wgt_addr,
   output logic [AW-1:0] dst_addr,
   output logic          acc_first,
   output logic          acc_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t r_state, w_state_nxt;
   logic   r_run_d;

   logic [3:0] r_id, r_od;
   logic [9:0] r_is, r_ks, r_fs, r_os;
   logic [4:0] r_iw, r_kh, r_kw, r_oh, r_ow;

   logic [3:0] r_o, r_c;
   logic [4:0] r_oy, r_ox, r_ky, r_kx;

   // Each loop level keeps the address at the start of its current iteration, so a wrap
   // of an inner loop reloads from the enclosing level plus one stride.
   logic [AW-1:0] r_src_oy, r_src_ox, r_src_c, r_src_ky, r_src;
   logic [AW-1:0] r_wgt_o, r_wgt_c, r_wgt_ky, r_wgt;
   logic [AW-1:0] r_dst_o, r_dst_oy, r_dst;

   logic w_start, w_zero, w_acc;
   logic w_kx_max, w_ky_max, w_c_max, w_ox_max, w_oy_max, w_o_max, w_all_max;
   logic [AW-1:0] w_src_ky_n, w_src_c_n, w_src_ox_n, w_src_oy_n;
   logic [AW-1:0] w_wgt_ky_n, w_wgt_c_n, w_wgt_o_n;
   logic [AW-1:0] w_dst_oy_n, w_dst_o_n;

   assign w_start = run & ~r_run_d;
   assign w_zero  = (id == 4'd0) | (kh == 5'd0) | (kw == 5'd0) |
                    (od == 4'd0) | (oh == 5'd0) | (ow == 5'd0);
   assign w_acc   = (r_state == S_RUN) & out_ready;

   assign w_kx_max  = (r_kx == r_kw - 5'd1);
   assign w_ky_max  = (r_ky == r_kh - 5'd1);
   assign w_c_max   = (r_c  == r_id - 4'd1);
   assign w_ox_max  = (r_ox == r_ow - 5'd1);
   assign w_oy_max  = (r_oy == r_oh - 5'd1);
   assign w_o_max   = (r_o  == r_od - 4'd1);
   assign w_all_max = w_kx_max & w_ky_max & w_c_max & w_ox_max & w_oy_max & w_o_max;

   assign w_src_ky_n = r_src_ky + AW'(r_iw);
   assign w_src_c_n  = r_src_c  + AW'(r_is);
   assign w_src_ox_n = r_src_ox + AW'(1);
   assign w_src_oy_n = r_src_oy + AW'(r_iw);
   assign w_wgt_ky_n = r_wgt_ky + AW'(r_kw);
   assign w_wgt_c_n  = r_wgt_c  + AW'(r_ks);
   assign w_wgt_o_n  = r_wgt_o  + AW'(r_fs);
   assign w_dst_oy_n = r_dst_oy + AW'(r_ow);
   assign w_dst_o_n  = r_dst_o  + AW'(r_os);

   assign src_addr = r_src;
   assign wgt_addr = r_wgt;
   assign dst_addr = r_dst;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_state <= S_IDLE;
         r_run_d <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_run_d <= run;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      out_valid   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      acc_first   = 1'b0;
      acc_last    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nxt = w_zero ? S_FIN : S_RUN;
         end
         S_RUN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            acc_first = (r_c == 4'd0) & (r_ky == 5'd0) & (r_kx == 5'd0);
            acc_last  = w_c_max & w_ky_max & w_kx_max;
            if (!run)                       w_state_nxt = S_IDLE;
            else if (w_acc && w_all_max)    w_state_nxt = S_FIN;
         end
         S_FIN: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_id <= '0; r_is <= '0; r_iw <= '0; r_ks <= '0; r_kh <= '0; r_kw <= '0;
         r_fs <= '0; r_od <= '0; r_os <= '0; r_oh <= '0; r_ow <= '0;
         r_o <= '0; r_oy <= '0; r_ox <= '0; r_c <= '0; r_ky <= '0; r_kx <= '0;
         r_src_oy <= '0; r_src_ox <= '0; r_src_c <= '0; r_src_ky <= '0; r_src <= '0;
         r_wgt_o <= '0; r_wgt_c <= '0; r_wgt_ky <= '0; r_wgt <= '0;
         r_dst_o <= '0; r_dst_oy <= '0; r_dst <= '0;
      end else if (r_state == S_IDLE && w_start) begin
         r_id <= id; r_is <= is; r_iw <= iw; r_ks <= ks; r_kh <= kh; r_kw <= kw;
         r_fs <= fs; r_od <= od; r_os <= os; r_oh <= oh; r_ow <= ow;
         r_o <= '0; r_oy <= '0; r_ox <= '0; r_c <= '0; r_ky <= '0; r_kx <= '0;
         r_src_oy <= '0; r_src_ox <= '0; r_src_c <= '0; r_src_ky <= '0; r_src <= '0;
         r_wgt_o <= '0; r_wgt_c <= '0; r_wgt_ky <= '0; r_wgt <= '0;
         r_dst_o <= '0; r_dst_oy <= '0; r_dst <= '0;
      end else if (w_acc) begin
         if (!w_kx_max) begin
            r_kx  <= r_kx + 5'd1;
            r_src <= r_src + AW'(1);
            r_wgt <= r_wgt + AW'(1);
         end else begin
            r_kx <= '0;
            if (!w_ky_max) begin
               r_ky     <= r_ky + 5'd1;
               r_src_ky <= w_src_ky_n; r_src <= w_src_ky_n;
               r_wgt_ky <= w_wgt_ky_n; r_wgt <= w_wgt_ky_n;
            end else begin
               r_ky <= '0;
               if (!w_c_max) begin
                  r_c     <= r_c + 4'd1;
                  r_src_c <= w_src_c_n; r_src_ky <= w_src_c_n; r_src <= w_src_c_n;
                  r_wgt_c <= w_wgt_c_n; r_wgt_ky <= w_wgt_c_n; r_wgt <= w_wgt_c_n;
               end else begin
                  r_c <= '0;
                  // Moving to a new output pixel restarts the weight walk for this o.
                  r_wgt_c <= r_wgt_o; r_wgt_ky <= r_wgt_o; r_wgt <= r_wgt_o;
                  if (!w_ox_max) begin
                     r_ox     <= r_ox + 5'd1;
                     r_src_ox <= w_src_ox_n; r_src_c <= w_src_ox_n;
                     r_src_ky <= w_src_ox_n; r_src   <= w_src_ox_n;
                     r_dst    <= r_dst + AW'(1);
                  end else begin
                     r_ox <= '0;
                     if (!w_oy_max) begin
                        r_oy     <= r_oy + 5'd1;
                        r_src_oy <= w_src_oy_n; r_src_ox <= w_src_oy_n; r_src_c <= w_src_oy_n;
                        r_src_ky <= w_src_oy_n; r_src    <= w_src_oy_n;
                        r_dst_oy <= w_dst_oy_n; r_dst    <= w_dst_oy_n;
                     end else begin
                        r_oy <= '0;
                        if (!w_o_max) begin
                           r_o      <= r_o + 4'd1;
                           r_src_oy <= '0; r_src_ox <= '0; r_src_c <= '0;
                           r_src_ky <= '0; r_src    <= '0;
                           r_wgt_o  <= w_wgt_o_n; r_wgt_c <= w_wgt_o_n;
                           r_wgt_ky <= w_wgt_o_n; r_wgt   <= w_wgt_o_n;
                           r_dst_o  <= w_dst_o_n; r_dst_oy <= w_dst_o_n; r_dst <= w_dst_o_n;
                        end
                     end
                  end
               end
            end
         end
      end
   end

endmodule
